// File: rtl/rr_interval_gen.sv
// RR-interval producer: synchronises a raw beat input, blanks a refractory window,
// and reports the ms interval between accepted beats. Optional averager under RR_AVG_EN.
module rr_interval_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int REFRACT_MS  = 200,
  parameter int CNT_MAX     = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        beat_in,
  input  logic        ms_tick,
  output logic [11:0] rr_interval_ms,
  output logic        new_rr_pulse,
  output logic        beat_pulse,
  output logic        armed,
  output logic        timeout_flag,
  output logic [7:0]  artifact_count,
  output logic [11:0] rr_avg_ms,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    REFRACT    = 2'd1,
    ARMED      = 2'd2
  } state_t;

  localparam logic [11:0] CNT_MAX_C = 12'(CNT_MAX);
  localparam logic [11:0] REFRACT_C = 12'(REFRACT_MS);

  state_t             state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               beat_s, beat_q, beat_edge;
  logic [11:0]        elapsed, elapsed_d;
  logic               refr_done;
  logic               accept, reject, new_rr_d;

  // Handshake: beat_pulse / new_rr_pulse are single-cycle strobes with no back-pressure;
  // rr_interval_ms is valid whenever new_rr_pulse is high and holds until the next one.

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      beat_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], beat_in};
      beat_q <= beat_s;
    end
  end

  assign beat_s    = sync_q[SYNC_STAGES-1];
  assign beat_edge = beat_s & ~beat_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_FIRST;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      WAIT_FIRST: if (beat_edge) state_next = REFRACT;
      REFRACT:    if (refr_done) state_next = ARMED;
      ARMED:      if (beat_edge) state_next = REFRACT;
      default:    state_next = WAIT_FIRST;
    endcase
  end

  // Output / action decode
  always_comb begin
    accept   = 1'b0;
    reject   = 1'b0;
    new_rr_d = 1'b0;
    case (state)
      WAIT_FIRST: accept = beat_edge;
      REFRACT:    reject = beat_edge;
      ARMED: begin
        accept   = beat_edge;
        new_rr_d = beat_edge;
      end
      default: ;
    endcase
  end

  assign armed     = (state == ARMED);
  assign state_dbg = state;

  // A tick coinciding with an accepted beat is dropped: the new interval starts at 0.
  always_comb begin
    elapsed_d = elapsed;
    if (accept || state == WAIT_FIRST)
      elapsed_d = 12'd0;
    else if (ms_tick && elapsed != CNT_MAX_C)
      elapsed_d = elapsed + 12'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elapsed        <= 12'd0;
      refr_done      <= 1'b0;
      rr_interval_ms <= 12'd0;
      new_rr_pulse   <= 1'b0;
      beat_pulse     <= 1'b0;
      timeout_flag   <= 1'b0;
      artifact_count <= 8'd0;
    end else begin
      elapsed      <= elapsed_d;
      // Compare on the next value so the flag is already low right after a beat reload.
      refr_done    <= (elapsed_d >= REFRACT_C);
      beat_pulse   <= accept;
      new_rr_pulse <= new_rr_d;
      if (new_rr_d)
        rr_interval_ms <= elapsed;
      if (accept)
        timeout_flag <= 1'b0;
      else if (state != WAIT_FIRST && elapsed_d == CNT_MAX_C)
        timeout_flag <= 1'b1;
      if (reject && artifact_count != 8'hFF)
        artifact_count <= artifact_count + 8'd1;
    end
  end

`ifdef RR_AVG_EN
  logic [14:0] acc;
  logic        seeded;

  // Exponential average with weight 1/8; acc holds 8x the average.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= 15'd6400;
      seeded <= 1'b0;
    end else if (new_rr_d) begin
      seeded <= 1'b1;
      if (!seeded) acc <= {elapsed, 3'b000};
      else         acc <= acc - (acc >> 3) + {3'b000, elapsed};
    end
  end

  assign rr_avg_ms = acc[14:3];
`else
  assign rr_avg_ms = 12'd0;
`endif

endmodule

// File: tb/tb_rr_interval_gen.sv
// Directed bench for rr_interval_gen: vector table for interval/refractory behaviour,
// plus hand sequences for saturation, timeout, tick/edge collision and reset.
module tb_rr_interval_gen;

  logic        clk;
  logic        rst_n;
  logic        beat_in;
  logic        ms_tick;
  logic [11:0] rr_interval_ms;
  logic        new_rr_pulse;
  logic        beat_pulse;
  logic        armed;
  logic        timeout_flag;
  logic [7:0]  artifact_count;
  logic [11:0] rr_avg_ms;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RR_AVG_EN
  localparam bit AVG_ON = 1'b1;
`else
  localparam bit AVG_ON = 1'b0;
`endif

  rr_interval_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .beat_in        (beat_in),
    .ms_tick        (ms_tick),
    .rr_interval_ms (rr_interval_ms),
    .new_rr_pulse   (new_rr_pulse),
    .beat_pulse     (beat_pulse),
    .armed          (armed),
    .timeout_flag   (timeout_flag),
    .artifact_count (artifact_count),
    .rr_avg_ms      (rr_avg_ms),
    .state_dbg      (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          gap;
    bit          acc;
    bit          nrr;
    logic [11:0] rr;
    logic [7:0]  art;
    bit          arm;
    logic [11:0] avg;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      ms_tick = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      ms_tick = 1'b0;
    end
  endtask

  // Raise beat_in and check strobes land exactly SYNC_STAGES+1 edges later.
  task automatic do_beat(input string name, input bit exp_acc, input bit exp_nrr,
                         input logic [11:0] exp_rr);
    beat_in = 1'b1;
    cyc();
    cyc();
    check({name, " early_pulse"}, 32'(beat_pulse), 32'd0);
    cyc();
    ms_tick = 1'b0;
    check({name, " beat_pulse"}, 32'(beat_pulse), 32'(exp_acc));
    check({name, " new_rr_pulse"}, 32'(new_rr_pulse), 32'(exp_nrr));
    check({name, " rr_interval_ms"}, 32'(rr_interval_ms), 32'(exp_rr));
    beat_in = 1'b0;
    cyc();
    check({name, " strobes_one_cycle"}, 32'({beat_pulse, new_rr_pulse}), 32'd0);
    cyc();
    cyc();
  endtask

  initial begin
    //          gap   acc nrr  rr    art arm avg
    vecs[0] = '{   0, 1, 0,    0, 0, 0, 800};
    vecs[1] = '{ 800, 1, 1,  800, 0, 1, 800};
    vecs[2] = '{ 150, 0, 0,  800, 1, 0, 800};
    vecs[3] = '{ 250, 1, 1,  400, 1, 1, 750};
    vecs[4] = '{ 200, 1, 1,  200, 1, 1, 681};
    vecs[5] = '{ 199, 0, 0,  200, 2, 0, 681};
    vecs[6] = '{ 101, 1, 1,  300, 2, 1, 633};
    vecs[7] = '{1000, 1, 1, 1000, 2, 1, 679};

    rst_n   = 1'b1;
    beat_in = 1'b0;
    ms_tick = 1'b0;

    // Asynchronous reset asserted mid-cycle
    #13 rst_n = 1'b0;
    #1;
    check("rst rr_interval_ms", 32'(rr_interval_ms), 32'd0);
    check("rst strobes", 32'({new_rr_pulse, beat_pulse}), 32'd0);
    check("rst armed", 32'(armed), 32'd0);
    check("rst timeout_flag", 32'(timeout_flag), 32'd0);
    check("rst artifact_count", 32'(artifact_count), 32'd0);
    check("rst rr_avg_ms", 32'(rr_avg_ms), AVG_ON ? 32'd800 : 32'd0);
    check("rst state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    cyc();

    foreach (vecs[i]) begin
      tick(vecs[i].gap);
      cyc();
      check($sformatf("vec%0d armed", i), 32'(armed), 32'(vecs[i].arm));
      do_beat($sformatf("vec%0d", i), vecs[i].acc, vecs[i].nrr, vecs[i].rr);
      check($sformatf("vec%0d artifact_count", i), 32'(artifact_count), 32'(vecs[i].art));
      check($sformatf("vec%0d rr_avg_ms", i), 32'(rr_avg_ms), AVG_ON ? 32'(vecs[i].avg) : 32'd0);
      check($sformatf("vec%0d armed_after", i), 32'(armed), 32'd0);
    end

    // Artifact counter saturation: stay in REFRACT (no ticks) and reject 300 edges
    for (int k = 0; k < 300; k++)
      do_beat("sat", 1'b0, 1'b0, 12'd1000);
    check("sat artifact_count", 32'(artifact_count), 32'd255);

    // Long gap: timeout rises exactly when elapsed reaches 4095
    tick(4094);
    check("timeout before", 32'(timeout_flag), 32'd0);
    tick(1);
    check("timeout at 4095", 32'(timeout_flag), 32'd1);
    tick(900);
    check("timeout held", 32'(timeout_flag), 32'd1);
    check("timeout armed", 32'(armed), 32'd1);
    do_beat("timeout beat", 1'b1, 1'b1, 12'd4095);
    check("timeout cleared", 32'(timeout_flag), 32'd0);

    // ms_tick held through the accepted edge: reports 600, coincident tick is dropped
    ms_tick = 1'b1;
    repeat (598) @(posedge clk);
    #1;
    do_beat("collide", 1'b1, 1'b1, 12'd600);
    tick(300);
    cyc();
    do_beat("after collide", 1'b1, 1'b1, 12'd300);

    // Reset mid-measurement with beat_in high at release: first beat again
    tick(50);
    beat_in = 1'b1;
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    check("midrst rr_interval_ms", 32'(rr_interval_ms), 32'd0);
    check("midrst artifact_count", 32'(artifact_count), 32'd0);
    check("midrst state", 32'(state_dbg), 32'd0);
    check("midrst rr_avg_ms", 32'(rr_avg_ms), AVG_ON ? 32'd800 : 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    cyc();
    check("release early_pulse", 32'(beat_pulse), 32'd0);
    cyc();
    check("release beat_pulse", 32'(beat_pulse), 32'd1);
    check("release new_rr_pulse", 32'(new_rr_pulse), 32'd0);
    beat_in = 1'b0;
    cyc();
    cyc();
    cyc();
    tick(800);
    cyc();
    do_beat("post reset", 1'b1, 1'b1, 12'd800);
    check("post reset rr_avg_ms", 32'(rr_avg_ms), AVG_ON ? 32'd800 : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
